// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: default bus widths, response kinds, and
// the byte-select width helper.
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;

  typedef enum logic [1:0] {WB_ACK, WB_ERR, WB_RTY} wb_resp_e;

  function automatic int wb_sel_w(input int dat_w);
    return dat_w / 8;
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: an output register plus one skid slot.
// in_ready depends only on registered state, so there is no combinational path from out_ready.
module wb_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] out_data_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic             out_valid_reg;
  logic             skid_valid_reg;
  logic             load_out;

  assign in_ready  = !skid_valid_reg;
  assign load_out  = out_ready || !out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_reg   <= '0;
      skid_data_reg  <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (load_out) begin
      // A parked beat always drains before a new one is taken, keeping order.
      if (skid_valid_reg) begin
        out_data_reg   <= skid_data_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else begin
        out_valid_reg <= in_valid;
        if (in_valid) out_data_reg <= in_data;
      end
    end else if (in_valid && in_ready) begin
      skid_data_reg  <= in_data;
      skid_valid_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/wb_pipe_bridge.sv
// Pipelined Wishbone B4 register bridge: skid-buffered request path, registered response path,
// outstanding-request limit and clean abort on s_cyc drop. Define WB_RTY_EN to add rty ports.
module wb_pipe_bridge
  import wb_pkg::*;
#(
  parameter int ADR_WIDTH = WB_ADR_W,
  parameter int DAT_WIDTH = WB_DAT_W,
  parameter int SEL_WIDTH = wb_sel_w(DAT_WIDTH),
  parameter int MAX_OUT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADR_WIDTH-1:0] s_adr,
  input  logic [DAT_WIDTH-1:0] s_dat_i,
  input  logic [SEL_WIDTH-1:0] s_sel,
  input  logic                 s_cyc,
  input  logic                 s_stb,
  input  logic                 s_we,
  output logic [DAT_WIDTH-1:0] s_dat_o,
  output logic                 s_ack,
  output logic                 s_err,
  output logic                 s_stall,
  output logic [ADR_WIDTH-1:0] m_adr,
  output logic [DAT_WIDTH-1:0] m_dat_o,
  output logic [SEL_WIDTH-1:0] m_sel,
  output logic                 m_cyc,
  output logic                 m_stb,
  output logic                 m_we,
  input  logic [DAT_WIDTH-1:0] m_dat_i,
  input  logic                 m_ack,
  input  logic                 m_err,
`ifdef WB_RTY_EN
  input  logic                 m_rty,
  output logic                 s_rty,
`endif
  input  logic                 m_stall
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int REQ_W = ADR_WIDTH + DAT_WIDTH + SEL_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 m_cyc_reg;
  logic                 resp_valid_reg;
  wb_resp_e             resp_kind_reg, resp_kind;
  logic [DAT_WIDTH-1:0] s_dat_reg;
  logic [REQ_W-1:0]     req_data, fwd_data;
  logic                 req_valid, req_ready, accept, flush;
  logic                 cnt_full, rty_in, resp_in, done;

`ifdef WB_RTY_EN
  assign rty_in = m_rty;
  assign s_rty  = resp_valid_reg && (resp_kind_reg == WB_RTY);
`else
  assign rty_in = 1'b0;
`endif

  // Master dropping cyc flushes everything in flight on the next edge.
  assign flush     = !s_cyc;
  assign cnt_full  = (cnt_reg == CNT_MAX);
  assign req_valid = s_cyc && s_stb && !cnt_full;
  assign accept    = req_valid && req_ready;
  assign s_stall   = !req_ready || cnt_full;
  assign req_data  = {s_adr, s_dat_i, s_sel, s_we};

  wb_skid_buf #(.WIDTH(REQ_W)) u_req_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (req_data),
    .in_valid  (req_valid),
    .in_ready  (req_ready),
    .out_data  (fwd_data),
    .out_valid (m_stb),
    .out_ready (!m_stall)
  );

  assign {m_adr, m_dat_o, m_sel, m_we} = fwd_data;
  assign m_cyc   = m_cyc_reg;
  assign s_dat_o = s_dat_reg;
  assign s_ack   = resp_valid_reg && (resp_kind_reg == WB_ACK);
  assign s_err   = resp_valid_reg && (resp_kind_reg == WB_ERR);

  // Responses outside an active cycle on both sides are stale and dropped.
  assign resp_in = m_cyc_reg && s_cyc && (m_ack || m_err || rty_in);
  assign done    = resp_valid_reg;

  always_comb begin
    resp_kind = WB_ACK;
    if (m_err)       resp_kind = WB_ERR;
    else if (rty_in) resp_kind = WB_RTY;
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (accept && !done)                         cnt_next = cnt_reg + CNT_W'(1);
    else if (!accept && done && cnt_reg != '0)   cnt_next = cnt_reg - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg        <= '0;
      m_cyc_reg      <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_kind_reg  <= WB_ACK;
      s_dat_reg      <= '0;
    end else begin
      cnt_reg        <= flush ? '0 : cnt_next;
      m_cyc_reg      <= s_cyc && (m_cyc_reg || accept);
      resp_valid_reg <= resp_in;
      resp_kind_reg  <= resp_kind;
      if (resp_in) s_dat_reg <= m_dat_i;
    end
  end

endmodule

// File: tb/tb_wb_pipe_bridge.sv
// Directed self-checking bench for wb_pipe_bridge with a 1-clk-latency pipelined slave model.
module tb_wb_pipe_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_adr, s_dat_i, s_dat_o, m_adr, m_dat_o, m_dat_i;
  logic [3:0]  s_sel, m_sel;
  logic        s_cyc, s_stb, s_we, s_ack, s_err, s_stall;
  logic        m_cyc, m_stb, m_we, m_ack, m_err, m_stall;
`ifdef WB_RTY_EN
  logic        m_rty, s_rty;
`endif

  int checks = 0;
  int errors = 0;
  int n_accept, ack_n, err_n, rty_n, stall_seen, slv_beat, err_beat, rty_beat;
  int resp_q[$];
  logic [31:0] rdq[$];
  int stall_hist[64];
  logic auto_ack;
  logic first_stb;
  logic [31:0] first_adr;

  always #5 clk = ~clk;

  wb_pipe_bridge #(.ADR_WIDTH(32), .DAT_WIDTH(32), .SEL_WIDTH(4), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst),
    .s_adr(s_adr), .s_dat_i(s_dat_i), .s_sel(s_sel), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_dat_o(s_dat_o), .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall),
    .m_adr(m_adr), .m_dat_o(m_dat_o), .m_sel(m_sel), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_dat_i(m_dat_i), .m_ack(m_ack), .m_err(m_err),
`ifdef WB_RTY_EN
    .m_rty(m_rty), .s_rty(s_rty),
`endif
    .m_stall(m_stall)
  );

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic int resp_total();
    return ack_n + err_n + rty_n;
  endfunction

  task automatic clear_obs();
    n_accept = 0; ack_n = 0; err_n = 0; rty_n = 0; stall_seen = 0; slv_beat = 0;
    resp_q.delete();
    rdq.delete();
  endtask

  // One clock: note what the coming edge accepts, then update the slave and observations.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = m_cyc & m_stb & !m_stall;
    a   = m_adr;
    if (s_cyc & s_stb & !s_stall) n_accept++;
    @(posedge clk);
    @(negedge clk);
    if (auto_ack) begin
      m_ack = 1'b0;
      m_err = 1'b0;
`ifdef WB_RTY_EN
      m_rty = 1'b0;
`endif
      if (acc) begin
        slv_beat++;
        m_dat_i = rd_data(a);
        if (slv_beat == err_beat) m_err = 1'b1;
`ifdef WB_RTY_EN
        else if (slv_beat == rty_beat) m_rty = 1'b1;
`endif
        else m_ack = 1'b1;
      end
    end
    if (s_ack) begin ack_n++; rdq.push_back(s_dat_o); resp_q.push_back(0); end
    if (s_err) begin err_n++; resp_q.push_back(1); end
`ifdef WB_RTY_EN
    if (s_rty) begin rty_n++; resp_q.push_back(2); end
`endif
    if (s_stall) stall_seen++;
  endtask

  task automatic end_cycle();
    s_cyc = 1'b0;
    s_stb = 1'b0;
    tick();
  endtask

  // Read burst of n beats; m_stall held high for stall_len clocks starting at clock stall_at.
  task automatic run_burst(input logic [31:0] base, input int n, input int stall_at, input int stall_len);
    int idx;
    int c;
    int start;
    logic go;
    idx = 0; c = 0; start = resp_total();
    s_cyc = 1'b1; s_we = 1'b0; s_sel = 4'hF;
    while (idx < n && c < 60) begin
      m_stall = (c >= stall_at) && (c < stall_at + stall_len);
      s_stb = 1'b1;
      s_adr = base + 4 * idx;
      stall_hist[c] = int'(s_stall);
      go = !s_stall;
      tick();
      if (c == 0) begin first_stb = m_stb; first_adr = m_adr; end
      if (go) idx++;
      c++;
    end
    s_stb = 1'b0; m_stall = 1'b0;
    while (resp_total() - start < n && c < 100) begin tick(); c++; end
    checks++;
    if (resp_total() - start != n) begin
      errors++;
      $display("FAIL burst_responses: got %0d responses, expected %0d", resp_total() - start, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ack, s_err, s_stall, m_stb, m_cyc, m_we} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000", {s_ack, s_err, s_stall, m_stb, m_cyc, m_we});
    end
    checks++;
    if (s_dat_o !== 32'h0) begin errors++; $display("FAIL reset_s_dat_o: got %h expected 0", s_dat_o); end
    checks++;
    if (m_adr !== 32'h0) begin errors++; $display("FAIL reset_m_adr: got %h expected 0", m_adr); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_burst_reads();
    clear_obs();
    run_burst(32'h100, 8, 99, 0);
    checks++;
    if (first_stb !== 1'b1 || first_adr !== 32'h100) begin
      errors++; $display("FAIL first_beat: got stb=%b adr=%h expected stb=1 adr=100", first_stb, first_adr);
    end
    checks++;
    if (ack_n != 8 || err_n != 0) begin errors++; $display("FAIL burst_acks: got ack=%0d err=%0d expected 8/0", ack_n, err_n); end
    checks++;
    if (stall_seen != 0) begin errors++; $display("FAIL burst_no_stall: got %0d stall clocks expected 0", stall_seen); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rdq[i] !== rd_data(32'h100 + 4 * i)) begin
        errors++; $display("FAIL burst_data[%0d]: got %h expected %h", i, rdq[i], rd_data(32'h100 + 4 * i));
      end
    end
    end_cycle();
    checks++;
    if (m_cyc !== 1'b0) begin errors++; $display("FAIL burst_end_m_cyc: got %b expected 0", m_cyc); end
  endtask

  task automatic test_stall_mid_burst();
    clear_obs();
    run_burst(32'h200, 8, 3, 3);
    checks++;
    if (stall_hist[3] != 0) begin errors++; $display("FAIL stall_before: got %0d expected 0", stall_hist[3]); end
    checks++;
    if (stall_hist[4] != 1) begin errors++; $display("FAIL stall_after_1clk: got %0d expected 1", stall_hist[4]); end
    checks++;
    if (ack_n != 8) begin errors++; $display("FAIL stall_acks: got %0d expected 8", ack_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rdq[i] !== rd_data(32'h200 + 4 * i)) begin
        errors++; $display("FAIL stall_data[%0d]: got %h expected %h", i, rdq[i], rd_data(32'h200 + 4 * i));
      end
    end
    end_cycle();
  endtask

  task automatic test_max_outstanding();
    clear_obs();
    auto_ack = 1'b0;
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 32'h300;
    repeat (8) tick();
    checks++;
    if (n_accept != 4) begin errors++; $display("FAIL max_accepts: got %0d expected 4", n_accept); end
    checks++;
    if (s_stall !== 1'b1) begin errors++; $display("FAIL max_stall: got %b expected 1", s_stall); end
    m_ack = 1'b1; m_dat_i = 32'hCAFE_0001;
    tick();
    m_ack = 1'b0;
    repeat (4) tick();
    checks++;
    if (n_accept != 5 || ack_n != 1) begin
      errors++; $display("FAIL max_one_more: got accepts=%0d acks=%0d expected 5/1", n_accept, ack_n);
    end
    checks++;
    if (s_stall !== 1'b1) begin errors++; $display("FAIL max_restall: got %b expected 1", s_stall); end
    end_cycle();
    checks++;
    if ({m_cyc, m_stb, s_stall} !== 3'b000) begin
      errors++; $display("FAIL max_abort: got cyc/stb/stall=%b expected 000", {m_cyc, m_stb, s_stall});
    end
    auto_ack = 1'b1;
  endtask

  task automatic test_err_beat();
    clear_obs();
    err_beat = 3;
    run_burst(32'h400, 5, 99, 0);
    err_beat = -1;
    tick();
    checks++;
    if (ack_n != 4 || err_n != 1) begin errors++; $display("FAIL err_counts: got ack=%0d err=%0d expected 4/1", ack_n, err_n); end
    checks++;
    if (resp_q[2] != 1 || resp_q[1] != 0 || resp_q[3] != 0) begin
      errors++; $display("FAIL err_position: got kinds %0d,%0d,%0d expected 0,1,0", resp_q[1], resp_q[2], resp_q[3]);
    end
    checks++;
    if (rdq[2] !== rd_data(32'h40C)) begin errors++; $display("FAIL err_next_data: got %h expected %h", rdq[2], rd_data(32'h40C)); end
    checks++;
    if (dut.cnt_reg !== 3'd0) begin errors++; $display("FAIL err_cnt: got %0d expected 0", dut.cnt_reg); end
    end_cycle();
  endtask

  task automatic test_abort();
    clear_obs();
    auto_ack = 1'b0;
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0;
    for (int i = 0; i < 3; i++) begin s_adr = 32'h500 + 4 * i; tick(); end
    checks++;
    if (n_accept != 3) begin errors++; $display("FAIL abort_accepts: got %0d expected 3", n_accept); end
    end_cycle();
    checks++;
    if ({m_cyc, m_stb} !== 2'b00) begin errors++; $display("FAIL abort_bus: got cyc/stb=%b expected 00", {m_cyc, m_stb}); end
    checks++;
    if (dut.cnt_reg !== 3'd0) begin errors++; $display("FAIL abort_cnt: got %0d expected 0", dut.cnt_reg); end
    m_ack = 1'b1; m_dat_i = 32'hDEAD_BEEF;
    repeat (2) tick();
    m_ack = 1'b0;
    repeat (2) tick();
    checks++;
    if (resp_total() != 0) begin errors++; $display("FAIL abort_late_ack: got %0d responses expected 0", resp_total()); end
    auto_ack = 1'b1;
    clear_obs();
    run_burst(32'h600, 4, 99, 0);
    checks++;
    if (rdq[0] !== rd_data(32'h600) || rdq[3] !== rd_data(32'h60C)) begin
      errors++; $display("FAIL abort_fresh_data: got %h,%h expected %h,%h", rdq[0], rdq[3], rd_data(32'h600), rd_data(32'h60C));
    end
    end_cycle();
  endtask

  task automatic test_reset_mid_burst();
    clear_obs();
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 32'h700;
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({s_ack, s_err, s_stall, m_stb, m_cyc} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_ctrl: got %b expected 00000", {s_ack, s_err, s_stall, m_stb, m_cyc});
    end
    checks++;
    if (m_adr !== 32'h0 || s_dat_o !== 32'h0) begin
      errors++; $display("FAIL rst_mid_data: got adr=%h dat=%h expected 0/0", m_adr, s_dat_o);
    end
    s_cyc = 1'b0; s_stb = 1'b0; m_ack = 1'b0; m_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_obs();
    run_burst(32'h800, 4, 99, 0);
    checks++;
    if (ack_n != 4 || rdq[0] !== rd_data(32'h800) || rdq[3] !== rd_data(32'h80C)) begin
      errors++; $display("FAIL rst_clean_burst: got acks=%0d d0=%h expected 4 d0=%h", ack_n, rdq[0], rd_data(32'h800));
    end
    end_cycle();
  endtask

`ifdef WB_RTY_EN
  task automatic test_rty();
    clear_obs();
    rty_beat = 2;
    run_burst(32'h900, 3, 99, 0);
    rty_beat = -1;
    tick();
    checks++;
    if (ack_n != 2 || rty_n != 1 || resp_q[1] != 2) begin
      errors++; $display("FAIL rty_resp: got ack=%0d rty=%0d kind1=%0d expected 2/1/2", ack_n, rty_n, resp_q[1]);
    end
    checks++;
    if (dut.cnt_reg !== 3'd0) begin errors++; $display("FAIL rty_cnt: got %0d expected 0", dut.cnt_reg); end
    end_cycle();
  endtask
`endif

  initial begin
    s_adr = '0; s_dat_i = '0; s_sel = '0; s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    m_dat_i = '0; m_ack = 1'b0; m_err = 1'b0; m_stall = 1'b0;
`ifdef WB_RTY_EN
    m_rty = 1'b0;
`endif
    auto_ack = 1'b1; err_beat = -1; rty_beat = -1;
    clear_obs();
    test_reset();
    test_burst_reads();
    test_stall_mid_burst();
    test_max_outstanding();
    test_err_beat();
    test_abort();
    test_reset_mid_burst();
`ifdef WB_RTY_EN
    test_rty();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
